// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART TX and RX paths: the default bit-cell divider
// for 4800 baud from the 100 MHz sysclk, the 8N1 frame geometry, and the
// bit-timing state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

    // 100 MHz / 4800 baud
    localparam int BAUD_DIV_DEFAULT = 20833;

    // One start bit, DATA_BITS data bits, one stop bit
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous byte FIFO feeding the UART transmitter. full and empty are
// registered and describe occupancy after each rising edge. A write while full
// is ignored; a read while empty is ignored. Simultaneous write and read both
// take effect and leave the occupancy unchanged.
//
// Ports:
//   sysclk   in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   wr_en    in   write strobe
//   wr_data  in   byte to store (DATA_BITS wide)
//   rd_en    in   pop strobe; rd_data is the head entry
//   rd_data  out  head of the FIFO (meaningful only while empty=0)
//   full     out  FIFO holds FIFO_DEPTH entries
//   empty    out  FIFO holds no entries
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 do_wr;
    logic                 do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CNT_W'(1);
        end else if (do_rd && !do_wr) begin
            count_next = count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read after it has been written, and the pointers/empty flag are reset.
    always_ff @(posedge sysclk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Buffered 8N1 UART transmitter. Bytes written by the CPU are queued in a
// small FIFO; a bit-timing state machine serialises each one as a start bit,
// DATA_BITS data bits LSB first and a stop bit, each held BAUD_DIV sysclk
// cycles. Back-to-back frames are separated by a single idle (pop) cycle.
//
// Ports:
//   sysclk    in   system clock, rising edge
//   reset     in   asynchronous active-low reset; aborts any frame
//   wr_en     in   byte write strobe
//   wr_data   in   byte to transmit, used only while wr_en=1
//   full      out  FIFO full; writes are dropped while set
//   empty     out  FIFO empty
//   busy      out  a frame is in progress
//   overflow  out  sticky flag, set when a write is dropped
//   tx_done   out  one-cycle pulse after each stop bit
//   UART_TX   out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 tx_done,
    output logic                 UART_TX
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 line, line_next;
    logic                 done, done_next;
    logic                 fifo_rd;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 cell_end;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (empty)
    );

    assign cell_end = (cnt == CNT_LAST);

    // Next-state logic. The line value for the next cell is decided at the
    // last cycle of the current cell so UART_TX stays a plain register.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        line_next    = line;
        done_next    = 1'b0;
        fifo_rd      = 1'b0;

        case (state)
            IDLE: begin
                line_next = 1'b1;
                if (!empty) begin
                    fifo_rd    = 1'b1;
                    shift_next = fifo_head;
                    line_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cell_end) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    line_next    = shift[0];
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cell_end) begin
                    cnt_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        line_next  = 1'b1;
                        state_next = STOP;
                    end else begin
                        // shift[1] is the bit that lands in shift[0] after this shift
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + IDX_W'(1);
                        line_next    = shift[1];
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cell_end) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                line_next  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            line    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            line    <= line_next;
            done    <= done_next;
        end
    end

    // Sticky: a dropped write is remembered until reset.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign tx_done = done;
    assign UART_TX = line;

endmodule
